// File: rtl/binarize_pack.sv
// binarize_pack
// Turns the serial stream of signed accumulator results from the PE column
// into packed binary activations for the next layer.
//
// For each accepted sample, the block compares the accumulator against the
// threshold of the current channel. That threshold is the folded batch-norm.
// The result can optionally be inverted per channel. The resulting bit goes
// into the next lane of a pack register. A full word, or a word cut short by
// acc_last, is pushed into a small output FIFO.
//
// Ports:
//   clk, rst_n                 rising-edge clock, async active-low reset
//   thr_wr/thr_addr/thr_data/thr_inv
//                              per-channel threshold table write port
//   acc_valid/acc_ready        accumulator sample handshake
//   acc_data                   signed accumulator value
//   acc_last                   last sample of a vector, flushes the partial word
//   act_valid/act_ready        packed word handshake
//   act_data                   packed bits, channel 0 at the LSB
//   act_last                   word closes a vector
module binarize_pack #(
   parameter int WIDTH = 16,
   parameter int ACC_W = 11,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     thr_wr,
   input  logic [$clog2(WIDTH)-1:0] thr_addr,
   input  logic [ACC_W-1:0]         thr_data,
   input  logic                     thr_inv,
   input  logic                     acc_valid,
   output logic                     acc_ready,
   input  logic [ACC_W-1:0]         acc_data,
   input  logic                     acc_last,
   output logic                     act_valid,
   input  logic                     act_ready,
   output logic [WIDTH-1:0]         act_data,
   output logic                     act_last
);

   localparam int LANE_W = $clog2(WIDTH);
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic [ACC_W-1:0]  thr_tab [WIDTH];
   logic [WIDTH-1:0]  inv_tab;

   logic [LANE_W-1:0] lane;
   logic [WIDTH-1:0]  pack;
   logic [WIDTH-1:0]  merged;

   logic [WIDTH-1:0]  fifo_data [DEPTH];
   logic [DEPTH-1:0]  fifo_last;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   logic              accept;
   logic              bit_val;
   logic              close_word;
   logic              push;
   logic              pop;

   // Ready depends only on the registered count.
   // This keeps act_ready out of the acc_ready path.
   assign acc_ready  = (count < CNT_W'(DEPTH));
   assign act_valid  = (count != '0);
   assign act_data   = fifo_data[rd_ptr];
   assign act_last   = fifo_last[rd_ptr];

   assign accept     = acc_valid && acc_ready;
   assign bit_val    = ($signed(acc_data) >= $signed(thr_tab[lane])) ^ inv_tab[lane];
   assign close_word = (lane == LANE_W'(WIDTH - 1)) || acc_last;
   assign push       = accept && close_word;
   assign pop        = act_valid && act_ready;

   // The pack register holds zeros above the current lane.
   // Because of that, merging the new bit in place gives the zero-padded word.
   always_comb begin
      merged       = pack;
      merged[lane] = bit_val;
   end

   // Threshold table.
   // A write on the same edge as an accept is not seen by that sample.
   // The sample reads the entry's previous contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            thr_tab[i] <= '0;
         end
         inv_tab <= '0;
      end else if (thr_wr) begin
         thr_tab[thr_addr] <= thr_data;
         inv_tab[thr_addr] <= thr_inv;
      end
   end

   // Lane counter and pack register.
   // Both restart from lane 0 whenever a word is closed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane <= '0;
         pack <= '0;
      end else if (accept) begin
         if (close_word) begin
            lane <= '0;
            pack <= '0;
         end else begin
            lane <= lane + LANE_W'(1);
            pack <= merged;
         end
      end
   end

   // Output FIFO storage and pointers.
   // Pointers wrap explicitly so that DEPTH does not need to be a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data[i] <= '0;
         end
         fifo_last <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= merged;
            fifo_last[wr_ptr] <= acc_last;
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         end
      end
   end

   // Occupancy count.
   // A simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_binarize_pack.sv
// tb_binarize_pack
// Directed bench for binarize_pack. It covers the following:
//   - reset state
//   - basic packing
//   - threshold and inversion behaviour
//   - flush on acc_last
//   - FIFO backpressure and drain order
//   - signed boundary comparisons
//   - write/accept same-cycle ordering
//   - asynchronous reset in the middle of a word
module tb_binarize_pack;

   logic        clk;
   logic        rst_n;
   logic        thr_wr;
   logic [3:0]  thr_addr;
   logic [10:0] thr_data;
   logic        thr_inv;
   logic        acc_valid;
   logic        acc_ready;
   logic [10:0] acc_data;
   logic        acc_last;
   logic        act_valid;
   logic        act_ready;
   logic [15:0] act_data;
   logic        act_last;

   int compared;
   int mismatched;

   binarize_pack #(.WIDTH(16), .ACC_W(11), .DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .thr_wr    (thr_wr),
      .thr_addr  (thr_addr),
      .thr_data  (thr_data),
      .thr_inv   (thr_inv),
      .acc_valid (acc_valid),
      .acc_ready (acc_ready),
      .acc_data  (acc_data),
      .acc_last  (acc_last),
      .act_valid (act_valid),
      .act_ready (act_ready),
      .act_data  (act_data),
      .act_last  (act_last)
   );

   // 10 time-unit clock.
   // Inputs change and outputs are sampled on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compares a 16-bit observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Compares a single-bit observed value against its expected value.
   task automatic checkBit(input string tag, input logic observed, input logic expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   // Offers one sample and returns on the falling edge after it is accepted.
   // The wait for acc_ready is bounded.
   // If the bound runs out, that shows up as a failed ready comparison.
   task automatic applyStimulus(input int value, input logic last);
      acc_valid = 1'b1;
      acc_data  = value[10:0];
      acc_last  = last;
      for (int i = 0; i < 50 && !acc_ready; i++) @(negedge clk);
      checkBit("acc_ready_before_accept", acc_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      acc_valid = 1'b0;
      acc_last  = 1'b0;
   endtask

   // Writes one threshold table entry.
   task automatic writeThr(input int addr, input int value, input logic inv);
      thr_wr   = 1'b1;
      thr_addr = addr[3:0];
      thr_data = value[10:0];
      thr_inv  = inv;
      @(negedge clk);
      thr_wr   = 1'b0;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      thr_wr     = 1'b0;
      thr_addr   = '0;
      thr_data   = '0;
      thr_inv    = 1'b0;
      acc_valid  = 1'b0;
      acc_data   = '0;
      acc_last   = 1'b0;
      act_ready  = 1'b1;

      // Reset state.
      repeat (2) @(negedge clk);
      checkBit("reset_act_valid", act_valid, 1'b0);
      checkOutput("reset_act_data", act_data, 16'h0000);
      checkBit("reset_act_last", act_last, 1'b0);
      checkBit("reset_acc_ready", acc_ready, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);

      // Alternating +2/-2 against zero thresholds gives 16'h5555.
      $display("[TB] alternating pattern");
      for (int i = 0; i < 15; i++) applyStimulus((i % 2 == 0) ? 2 : -2, 1'b0);
      checkBit("alt_no_word_before_16th", act_valid, 1'b0);
      applyStimulus(-2, 1'b0);
      checkBit("alt_valid", act_valid, 1'b1);
      checkOutput("alt_data", act_data, 16'h5555);
      checkBit("alt_last", act_last, 1'b0);
      @(negedge clk);
      checkBit("alt_valid_one_cycle", act_valid, 1'b0);

      // thr[3]=5 clears bit 3, and inv[7]=1 clears bit 7.
      $display("[TB] threshold and invert");
      writeThr(3, 5, 1'b0);
      writeThr(7, 0, 1'b1);
      for (int i = 0; i < 16; i++) applyStimulus(4, 1'b0);
      checkBit("thr_valid", act_valid, 1'b1);
      checkOutput("thr_data", act_data, 16'hFF77);
      @(negedge clk);

      // A short vector flushed by acc_last.
      // The next word must then start again at lane 0.
      $display("[TB] flush on last");
      writeThr(3, 0, 1'b0);
      writeThr(7, 0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0);
      applyStimulus(1, 1'b1);
      checkBit("flush_valid", act_valid, 1'b1);
      checkOutput("flush_data", act_data, 16'h001F);
      checkBit("flush_last", act_last, 1'b1);
      @(negedge clk);
      for (int i = 0; i < 15; i++) applyStimulus(1, 1'b0);
      checkBit("after_flush_no_early_word", act_valid, 1'b0);
      applyStimulus(1, 1'b0);
      checkOutput("after_flush_data", act_data, 16'hFFFF);
      checkBit("after_flush_last", act_last, 1'b0);
      @(negedge clk);

      // Backpressure: two words fill the FIFO and acc_ready drops.
      // The words then drain in order.
      $display("[TB] backpressure");
      act_ready = 1'b0;
      for (int i = 0; i < 16; i++) applyStimulus(1, 1'b0);
      for (int i = 0; i < 16; i++) applyStimulus(-1, 1'b0);
      checkBit("full_acc_ready", acc_ready, 1'b0);
      checkBit("full_act_valid", act_valid, 1'b1);
      checkOutput("full_head_data", act_data, 16'hFFFF);
      acc_valid = 1'b1;
      acc_data  = 11'd1;
      repeat (3) @(negedge clk);
      checkBit("stall_acc_ready", acc_ready, 1'b0);
      checkOutput("stall_head_stable", act_data, 16'hFFFF);
      acc_valid = 1'b0;
      act_ready = 1'b1;
      @(negedge clk);
      checkBit("drain_second_valid", act_valid, 1'b1);
      checkOutput("drain_second_data", act_data, 16'h0000);
      checkBit("drain_acc_ready", acc_ready, 1'b1);
      @(negedge clk);
      checkBit("drain_empty", act_valid, 1'b0);
      for (int i = 0; i < 16; i++) applyStimulus(1, 1'b0);
      checkOutput("third_word_data", act_data, 16'hFFFF);
      @(negedge clk);

      // Signed extremes of the accumulator range.
      $display("[TB] boundary values");
      writeThr(0, -1024, 1'b0);
      writeThr(1, 1023, 1'b0);
      applyStimulus(-1024, 1'b0);
      applyStimulus(1023, 1'b0);
      applyStimulus(-1, 1'b1);
      checkOutput("boundary_data", act_data, 16'h0003);
      checkBit("boundary_last", act_last, 1'b1);
      @(negedge clk);

      // A threshold write on the accepting edge is not seen by that sample.
      // The sample still uses the old thr[0] of -1024.
      // The next sample uses the new value of 100.
      $display("[TB] write/accept ordering");
      thr_wr   = 1'b1;
      thr_addr = 4'd0;
      thr_data = 11'd100;
      thr_inv  = 1'b0;
      applyStimulus(50, 1'b1);
      thr_wr = 1'b0;
      checkOutput("same_cycle_old_thr", act_data, 16'h0001);
      @(negedge clk);
      applyStimulus(50, 1'b1);
      checkBit("new_thr_valid", act_valid, 1'b1);
      checkOutput("new_thr_data", act_data, 16'h0000);
      @(negedge clk);

      // Asynchronous reset with one word queued and 9 lanes partly packed.
      $display("[TB] async reset mid-word");
      act_ready = 1'b0;
      for (int i = 0; i < 16; i++) applyStimulus(1, 1'b0);
      for (int i = 0; i < 9; i++) applyStimulus(1, 1'b0);
      checkBit("pre_reset_valid", act_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      checkBit("async_reset_valid", act_valid, 1'b0);
      checkBit("async_reset_acc_ready", acc_ready, 1'b1);
      checkOutput("async_reset_data", act_data, 16'h0000);
      @(negedge clk);
      rst_n     = 1'b1;
      act_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 15; i++) applyStimulus(1, 1'b0);
      checkBit("post_reset_no_early_word", act_valid, 1'b0);
      applyStimulus(1, 1'b0);
      checkBit("post_reset_valid", act_valid, 1'b1);
      checkOutput("post_reset_data", act_data, 16'hFFFF);
      checkBit("post_reset_last", act_last, 1'b0);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
